mc_ctrl_fsm: RTL and testbench
==============================

Name: mc_ctrl_fsm

Overview:
- Parametrised multi-cycle MIPS main control FSM. It is the next generation of the fixed state machine plus control-signal decoder pair.
- Drives all datapath control strobes for lw, sw, R-type, beq, addi and j.
- Adds a memory request/ready handshake with wait states, a memory timeout with a halt state, and a retired-instruction counter.
- Sits between the instruction register (opcode/funct) and the datapath/memory.

Parameters:
- CNT_W, 32: width of the retired-instruction counter.
- MEM_TIMEOUT, 15: maximum wait cycles for mem_ready before a bus error (range 1..255).
- TO_W, 8: width of the timeout counter. It must hold MEM_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  6  instr[31:26] from the IR; sampled in DECODE.
- funct  in  6  instr[5:0]; used in EXEC.
- zero  in  1  ALU zero flag; used in BRANCH.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- iord  out  1  0 = PC address, 1 = ALUOut address.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  IR load.
- pc_write  out  1  unconditional PC load.
- branch  out  1  conditional PC load (datapath ANDs it with zero).
- pc_src  out  2  00 ALU, 01 ALUOut, 10 jump target.
- alu_src_a  out  1  0 PC, 1 register A.
- alu_src_b  out  2  00 B, 01 const 4, 10 sign-extended imm, 11 imm<<2.
- alu_op  out  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
- reg_write  out  1  register-file write enable.
- reg_dst  out  1  0 = rt, 1 = rd.
- mem_to_reg  out  1  0 = ALUOut, 1 = MDR.
- state  out  4  current state encoding.
- halted  out  1  FSM is in HALT.
- bus_err  out  1  sticky: a memory timeout occurred.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- Reset (asynchronous, while rst = 1):
  - State goes to IDLE.
  - All outputs are 0: retired = 0, bus_err = 0, timeout counter = 0.
  - Reset mid-access abandons the access. mem_req drops within the same cycle.
- States: IDLE = 0, FETCH = 1, DECODE = 2, MEMADR = 3, MEMRD = 4, MEMWB = 5, MEMWR = 6, EXEC = 7, ALUWB = 8, BRANCH = 9, ADDIEX = 10, ADDIWB = 11, JUMP = 12, HALT = 15.
- Outputs are Moore, decoded from state. Exception: ir_write and pc_write in FETCH are asserted only when mem_ready = 1.
- IDLE: all outputs 0. Goes to FETCH on the first clock after reset release.
- FETCH:
  - mem_req = 1, iord = 0, alu_src_a = 0, alu_src_b = 01, alu_op = ADD, pc_src = 00.
  - Stays in FETCH while mem_ready = 0. Goes to DECODE on mem_ready = 1, together with ir_write = pc_write = 1.
- DECODE: alu_src_a = 0, alu_src_b = 11, alu_op = ADD. Next state by opcode:
  - 100011 or 101011 -> MEMADR
  - 000000 -> EXEC
  - 000100 -> BRANCH
  - 001000 -> ADDIEX
  - 000010 -> JUMP
  - any other opcode -> see Optional Feature.
- MEMADR: alu_src_a = 1, alu_src_b = 10, alu_op = ADD. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: mem_req = 1, iord = 1. Waits for mem_ready, then goes to MEMWB.
- MEMWB: reg_write = 1, reg_dst = 0, mem_to_reg = 1. Goes to FETCH.
- MEMWR: mem_req = 1, iord = 1, mem_write = 1. Waits for mem_ready, then goes to FETCH.
- EXEC: alu_src_a = 1, alu_src_b = 00. alu_op from funct:
  - 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT.
  - Any other funct gives ADD.
  - Goes to ALUWB.
- ALUWB: reg_write = 1, reg_dst = 1, mem_to_reg = 0. Goes to FETCH.
- BRANCH: alu_src_a = 1, alu_src_b = 00, alu_op = SUB, branch = 1, pc_src = 01. Goes to FETCH.
- ADDIEX: alu_src_a = 1, alu_src_b = 10, alu_op = ADD. Goes to ADDIWB.
- ADDIWB: reg_write = 1, reg_dst = 0, mem_to_reg = 0. Goes to FETCH.
- JUMP: pc_write = 1, pc_src = 10. Goes to FETCH.
- Timeout:
  - The counter clears on entry to any wait state (FETCH, MEMRD, MEMWR).
  - It increments each cycle the FSM waits with mem_ready = 0.
  - When the counter reaches MEM_TIMEOUT with mem_ready still 0: bus_err is set and the FSM goes to HALT.
  - If mem_ready = 1 arrives in the same cycle the counter reaches MEM_TIMEOUT, ready wins and there is no error.
- HALT: all strobes 0, halted = 1. Only reset exits HALT.
- retired:
  - Increments by 1 on each transition into FETCH from MEMWB, MEMWR (completed), ALUWB, BRANCH, ADDIWB or JUMP.
  - Wraps modulo 2^CNT_W.
  - Does not count branch taken/not-taken separately.

Optional Feature:
- Macro: MC_ILLEGAL_TRAP_EN.
- Defined: an unknown opcode in DECODE goes to HALT and sets output illegal_op (1 bit, sticky, cleared by reset). retired is not incremented.
- Undefined: an unknown opcode is a NOP. DECODE goes to FETCH, retired increments, and there is no illegal_op port.

Test Plan:
- Reset, then mem_ready tied 1 and opcode 000000 / funct 100010 -> states IDLE, FETCH, DECODE, EXEC (alu_op = 110), ALUWB (reg_write = 1, reg_dst = 1), FETCH; retired = 1.
- lw with mem_ready delayed 3 cycles in MEMRD -> MEMRD held 4 cycles with mem_req = 1, iord = 1; then MEMWB with mem_to_reg = 1; retired increments once.
- beq with MEM_TIMEOUT = 15 -> BRANCH asserts branch = 1, pc_src = 01, alu_op = 110 for exactly 1 cycle; sw waits in MEMWR; 100 back-to-back addi instructions -> retired = 100.
- mem_ready held 0 in FETCH -> after 15 wait cycles bus_err = 1, halted = 1, state = 15; state is still 15 after 50 more cycles; rst pulse returns state to 0 with bus_err = 0.
- Opcode 111111 -> with the macro: HALT and illegal_op = 1, retired unchanged. Without the macro: returns to FETCH and retired increments.
- rst asserted mid-MEMWR (between clock edges) -> mem_write and mem_req go to 0 immediately; state = 0.

Source files
------------

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS main control FSM with memory handshake, timeout/halt and
// a retired-instruction counter.
// Optional build macro MC_ILLEGAL_TRAP_EN: unknown opcodes trap to HALT and
// raise a sticky illegal_op_o; otherwise they retire as NOPs.
module mc_ctrl_fsm #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned TO_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode_i,
  input  logic [5:0]       funct_i,
  input  logic             zero_i,
  input  logic             mem_ready_i,
  output logic             mem_req_o,
  output logic             iord_o,
  output logic             mem_write_o,
  output logic             ir_write_o,
  output logic             pc_write_o,
  output logic             branch_o,
  output logic [1:0]       pc_src_o,
  output logic             alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic [2:0]       alu_op_o,
  output logic             reg_write_o,
  output logic             reg_dst_o,
  output logic             mem_to_reg_o,
  output logic [3:0]       state_o,
  output logic             halted_o,
  output logic             bus_err_o,
`ifdef MC_ILLEGAL_TRAP_EN
  output logic             illegal_op_o,
`endif
  output logic [CNT_W-1:0] retired_o
);

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,  S_FETCH  = 4'd1,  S_DECODE = 4'd2,  S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,  S_MEMWB  = 4'd5,  S_MEMWR  = 4'd6,  S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,  S_BRANCH = 4'd9,  S_ADDIEX = 4'd10, S_ADDIWB = 4'd11,
    S_JUMP   = 4'd12, S_HALT   = 4'd15
  } state_e;

  state_e            state_q, state_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic              bus_err_q, bus_err_d;
  logic              is_sw_q, is_sw_d;
  logic              retire_c;
`ifdef MC_ILLEGAL_TRAP_EN
  logic              illegal_q, illegal_d;
`endif

  // The branch decision is made in the datapath (branch & zero); zero is not needed here.
  logic unused_zero;
  assign unused_zero = zero_i;

  // State, timeout counter, retire counter and sticky flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      to_q      <= '0;
      retired_q <= '0;
      bus_err_q <= 1'b0;
      is_sw_q   <= 1'b0;
`ifdef MC_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      to_q      <= to_d;
      retired_q <= retired_d;
      bus_err_q <= bus_err_d;
      is_sw_q   <= is_sw_d;
`ifdef MC_ILLEGAL_TRAP_EN
      illegal_q <= illegal_d;
`endif
    end
  end

  // Next state; timeout counter only survives while a wait state keeps waiting.
  always_comb begin
    state_d   = state_q;
    to_d      = '0;
    retire_c  = 1'b0;
    bus_err_d = bus_err_q;
    is_sw_d   = is_sw_q;
`ifdef MC_ILLEGAL_TRAP_EN
    illegal_d = illegal_q;
`endif
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH, S_MEMRD, S_MEMWR: begin
        if (mem_ready_i) begin
          if (state_q == S_FETCH) begin
            state_d = S_DECODE;
          end else if (state_q == S_MEMRD) begin
            state_d = S_MEMWB;
          end else begin
            state_d  = S_FETCH;
            retire_c = 1'b1;
          end
        end else if (to_q == TO_W'(MEM_TIMEOUT)) begin
          state_d   = S_HALT;
          bus_err_d = 1'b1;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      S_DECODE: begin
        is_sw_d = (opcode_i == 6'b101011);
        case (opcode_i)
          6'b100011, 6'b101011: state_d = S_MEMADR;
          6'b000000:            state_d = S_EXEC;
          6'b000100:            state_d = S_BRANCH;
          6'b001000:            state_d = S_ADDIEX;
          6'b000010:            state_d = S_JUMP;
          default: begin
`ifdef MC_ILLEGAL_TRAP_EN
            state_d   = S_HALT;
            illegal_d = 1'b1;
`else
            state_d  = S_FETCH;
            retire_c = 1'b1;
`endif
          end
        endcase
      end
      S_MEMADR: state_d = is_sw_q ? S_MEMWR : S_MEMRD;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: begin
        state_d  = S_FETCH;
        retire_c = 1'b1;
      end
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
    retired_d = retire_c ? (retired_q + CNT_W'(1)) : retired_q;
  end

  // Moore control decode; FETCH qualifies the IR/PC loads with mem_ready.
  always_comb begin
    mem_req_o    = 1'b0;
    iord_o       = 1'b0;
    mem_write_o  = 1'b0;
    ir_write_o   = 1'b0;
    pc_write_o   = 1'b0;
    branch_o     = 1'b0;
    pc_src_o     = 2'b00;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = 2'b00;
    alu_op_o     = ALU_AND;
    reg_write_o  = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    halted_o     = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req_o   = 1'b1;
        alu_src_b_o = 2'b01;
        alu_op_o    = ALU_ADD;
        ir_write_o  = mem_ready_i;
        pc_write_o  = mem_ready_i;
      end
      S_DECODE: begin
        alu_src_b_o = 2'b11;
        alu_op_o    = ALU_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        alu_op_o    = ALU_ADD;
      end
      S_MEMRD: begin
        mem_req_o = 1'b1;
        iord_o    = 1'b1;
      end
      S_MEMWB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
      end
      S_MEMWR: begin
        mem_req_o   = 1'b1;
        iord_o      = 1'b1;
        mem_write_o = 1'b1;
      end
      S_EXEC: begin
        alu_src_a_o = 1'b1;
        case (funct_i)
          6'b100010: alu_op_o = ALU_SUB;
          6'b100100: alu_op_o = ALU_AND;
          6'b100101: alu_op_o = ALU_OR;
          6'b101010: alu_op_o = ALU_SLT;
          default:   alu_op_o = ALU_ADD;
        endcase
      end
      S_ALUWB: begin
        reg_write_o = 1'b1;
        reg_dst_o   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALU_SUB;
        branch_o    = 1'b1;
        pc_src_o    = 2'b01;
      end
      S_ADDIWB: reg_write_o = 1'b1;
      S_JUMP: begin
        pc_write_o = 1'b1;
        pc_src_o   = 2'b10;
      end
      S_HALT:  halted_o = 1'b1;
      default: ;
    endcase
  end

  assign state_o   = 4'(state_q);
  assign bus_err_o = bus_err_q;
  assign retired_o = retired_q;
`ifdef MC_ILLEGAL_TRAP_EN
  assign illegal_op_o = illegal_q;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: instruction-level model expands each instruction
// into its expected per-cycle state/ready/counter trace, checked every cycle.
module tb_mc_ctrl_fsm;

  localparam int unsigned CNT_W       = 32;
  localparam int unsigned MEM_TIMEOUT = 15;
  localparam int unsigned TO_W        = 8;

  localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_MEMADR = 4'd3,
                         S_MEMRD = 4'd4, S_MEMWB = 4'd5, S_MEMWR = 4'd6, S_EXEC = 4'd7,
                         S_ALUWB = 4'd8, S_BRANCH = 4'd9, S_ADDIEX = 4'd10, S_ADDIWB = 4'd11,
                         S_JUMP = 4'd12, S_HALT = 4'd15;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010,
                         OP_BAD = 6'b111111;

  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       branch;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       halted;
  } ctrl_t;

  typedef struct {
    logic [3:0]       st;
    logic             rdy;
    logic [5:0]       op;
    logic [5:0]       fn;
    logic             zero;
    logic [CNT_W-1:0] ret;
    logic             berr;
    logic             ill;
  } cyc_t;

  logic clk, rst, zero, mem_ready;
  logic [5:0] opcode, funct;
  logic mem_req, iord, mem_write, ir_write, pc_write, branch, alu_src_a;
  logic reg_write, reg_dst, mem_to_reg, halted, bus_err;
  logic [1:0] pc_src, alu_src_b;
  logic [2:0] alu_op;
  logic [3:0] state;
  logic [CNT_W-1:0] retired;
`ifdef MC_ILLEGAL_TRAP_EN
  logic illegal_op;
`endif

  mc_ctrl_fsm #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT), .TO_W(TO_W)) dut (
    .clk(clk), .rst(rst), .opcode_i(opcode), .funct_i(funct), .zero_i(zero),
    .mem_ready_i(mem_ready), .mem_req_o(mem_req), .iord_o(iord), .mem_write_o(mem_write),
    .ir_write_o(ir_write), .pc_write_o(pc_write), .branch_o(branch), .pc_src_o(pc_src),
    .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b), .alu_op_o(alu_op),
    .reg_write_o(reg_write), .reg_dst_o(reg_dst), .mem_to_reg_o(mem_to_reg),
    .state_o(state), .halted_o(halted), .bus_err_o(bus_err),
`ifdef MC_ILLEGAL_TRAP_EN
    .illegal_op_o(illegal_op),
`endif
    .retired_o(retired)
  );

  ctrl_t act_c;
  assign act_c = {mem_req, iord, mem_write, ir_write, pc_write, branch, pc_src, alu_src_a,
                  alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg, halted};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int idx = 0;
  logic run_active = 1'b0;
  logic rdy_rand = 1'b0;

  // Model state (instruction level)
  cyc_t tr[$];
  int unsigned m_ret;
  logic m_berr, m_ill, m_halted;
  logic [5:0] cur_op, cur_fn;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (trace cycle %0d): got %h expected %h", name, idx, act, exp);
  endtask

  function automatic logic [2:0] alu_for_funct(input logic [5:0] fn);
    case (fn)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Control strobes each state must show, straight from the state table.
  function automatic ctrl_t exp_ctrl(input logic [3:0] st, input logic rdy, input logic [5:0] fn);
    ctrl_t c;
    c = '0;
    case (st)
      S_FETCH:  begin c.mem_req = 1; c.alu_src_b = 2'b01; c.alu_op = 3'b010;
                      c.ir_write = rdy; c.pc_write = rdy; end
      S_DECODE: begin c.alu_src_b = 2'b11; c.alu_op = 3'b010; end
      S_MEMADR: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_op = 3'b010; end
      S_MEMRD:  begin c.mem_req = 1; c.iord = 1; end
      S_MEMWB:  begin c.reg_write = 1; c.mem_to_reg = 1; end
      S_MEMWR:  begin c.mem_req = 1; c.iord = 1; c.mem_write = 1; end
      S_EXEC:   begin c.alu_src_a = 1; c.alu_op = alu_for_funct(fn); end
      S_ALUWB:  begin c.reg_write = 1; c.reg_dst = 1; end
      S_BRANCH: begin c.alu_src_a = 1; c.alu_op = 3'b110; c.branch = 1; c.pc_src = 2'b01; end
      S_ADDIEX: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_op = 3'b010; end
      S_ADDIWB: c.reg_write = 1;
      S_JUMP:   begin c.pc_write = 1; c.pc_src = 2'b10; end
      S_HALT:   c.halted = 1;
      default:  ;
    endcase
    return c;
  endfunction

  task automatic push(input logic [3:0] st, input logic rdy);
    cyc_t e;
    e.st   = st;
    e.rdy  = rdy;
    e.op   = (st == S_DECODE) ? cur_op : 6'($urandom);
    e.fn   = (st == S_EXEC) ? cur_fn : 6'($urandom);
    e.zero = 1'($urandom);
    e.ret  = CNT_W'(m_ret);
    e.berr = m_berr;
    e.ill  = m_ill;
    tr.push_back(e);
  endtask

  task automatic push_s(input logic [3:0] st);
    push(st, rdy_rand ? 1'($urandom) : 1'b1);
  endtask

  // A wait state answered after d idle cycles; past the timeout it halts.
  task automatic add_wait(input logic [3:0] st, input int d);
    for (int w = 0; w <= int'(MEM_TIMEOUT); w++) begin
      if (w == d) begin
        push(st, 1'b1);
        return;
      end
      push(st, 1'b0);
    end
    m_halted = 1'b1;
    m_berr   = 1'b1;
  endtask

  task automatic add_instr(input logic [5:0] op, input logic [5:0] fn, input int df, input int dm);
    if (m_halted) return;
    cur_op = op;
    cur_fn = fn;
    add_wait(S_FETCH, df);
    if (m_halted) return;
    push_s(S_DECODE);
    case (op)
      OP_LW: begin
        push_s(S_MEMADR);
        add_wait(S_MEMRD, dm);
        if (m_halted) return;
        push_s(S_MEMWB);
      end
      OP_SW: begin
        push_s(S_MEMADR);
        add_wait(S_MEMWR, dm);
        if (m_halted) return;
      end
      OP_R:    begin push_s(S_EXEC); push_s(S_ALUWB); end
      OP_BEQ:  push_s(S_BRANCH);
      OP_ADDI: begin push_s(S_ADDIEX); push_s(S_ADDIWB); end
      OP_J:    push_s(S_JUMP);
      default: begin
`ifdef MC_ILLEGAL_TRAP_EN
        m_halted = 1'b1;
        m_ill    = 1'b1;
        return;
`endif
      end
    endcase
    m_ret++;
  endtask

  task automatic add_halt(input int n);
    if (!m_halted) return;
    for (int i = 0; i < n; i++) push(S_HALT, 1'($urandom));
  endtask

  function automatic logic [5:0] pick_op(input int unsigned s);
    case (s)
      0: return OP_LW;
      1: return OP_SW;
      2: return OP_R;
      3: return OP_BEQ;
      4: return OP_ADDI;
      default: return OP_J;
    endcase
  endfunction

  function automatic logic [5:0] pick_fn(input int unsigned s);
    case (s)
      0: return 6'b100000;
      1: return 6'b100010;
      2: return 6'b100100;
      3: return 6'b100101;
      4: return 6'b101010;
      default: return 6'($urandom);
    endcase
  endfunction

  function automatic int rnd_delay();
    if ($urandom_range(0, 9) == 0) return int'($urandom_range(4, MEM_TIMEOUT));
    return int'($urandom_range(0, 2));
  endfunction

  // Starts and ends just after a rising edge.
  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'b0;
    opcode = '0;
    funct = '0;
    @(posedge clk); #1;
    chk("reset_ctrl", 64'(act_c), 64'(0));
    chk("reset_state", 64'(state), 64'(S_IDLE));
    chk("reset_retired", 64'(retired), 64'(0));
    chk("reset_bus_err", 64'(bus_err), 64'(0));
`ifdef MC_ILLEGAL_TRAP_EN
    chk("reset_illegal", 64'(illegal_op), 64'(0));
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    tr.delete();
    m_ret = 0;
    m_berr = 1'b0;
    m_ill = 1'b0;
    m_halted = 1'b0;
    push_s(S_IDLE);
  endtask

  task automatic run_trace(input int n);
    run_active = 1'b1;
    for (int i = 0; i < n; i++) begin
      idx       = i;
      opcode    = tr[i].op;
      funct     = tr[i].fn;
      zero      = tr[i].zero;
      mem_ready = tr[i].rdy;
      @(posedge clk); #1;
    end
    run_active = 1'b0;
    mem_ready  = 1'b0;
  endtask

  // Per-cycle compare against the expanded trace.
  cyc_t ce;
  always @(negedge clk) begin
    if (run_active) begin
      ce = tr[idx];
      chk("ctrl", 64'(act_c), 64'(exp_ctrl(ce.st, ce.rdy, ce.fn)));
      chk("state", 64'(state), 64'(ce.st));
      chk("retired", 64'(retired), 64'(ce.ret));
      chk("bus_err", 64'(bus_err), 64'(ce.berr));
`ifdef MC_ILLEGAL_TRAP_EN
      chk("illegal_op", 64'(illegal_op), 64'(ce.ill));
`endif
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;

    // R-type SUB with memory always ready
    rdy_rand = 1'b0;
    do_reset();
    add_instr(OP_R, 6'b100010, 0, 0);
    run_trace(tr.size());
    chk("sub_end_state", 64'(state), 64'(S_FETCH));
    chk("sub_retired", 64'(retired), 64'(1));

    // lw with three wait cycles in MEMRD
    do_reset();
    add_instr(OP_LW, 6'b000000, 0, 3);
    run_trace(tr.size());
    chk("lw_retired", 64'(retired), 64'(1));

    // beq, sw waits, ready exactly at the timeout boundary, then random mix
    rdy_rand = 1'b1;
    do_reset();
    add_instr(OP_BEQ, 6'b000000, 1, 0);
    add_instr(OP_SW, 6'b000000, 0, 2);
    add_instr(OP_LW, 6'b000000, int'(MEM_TIMEOUT), int'(MEM_TIMEOUT));
    add_instr(OP_SW, 6'b000000, 0, int'(MEM_TIMEOUT));
    for (int k = 0; k < 200; k++) begin
      add_instr(pick_op($urandom_range(0, 5)), pick_fn($urandom_range(0, 5)),
                rnd_delay(), rnd_delay());
    end
    run_trace(tr.size());
    chk("rand_bus_err", 64'(bus_err), 64'(0));
    chk("rand_retired", 64'(retired), 64'(204));

    // 100 back-to-back addi
    rdy_rand = 1'b0;
    do_reset();
    for (int k = 0; k < 100; k++) add_instr(OP_ADDI, 6'b000000, 0, 0);
    run_trace(tr.size());
    chk("addi100_retired", 64'(retired), 64'(100));

    // FETCH never answered -> bus error and HALT that persists
    rdy_rand = 1'b1;
    do_reset();
    add_instr(OP_R, 6'b100000, int'(MEM_TIMEOUT) + 1, 0);
    add_halt(50);
    run_trace(tr.size());
    chk("to_state", 64'(state), 64'(S_HALT));
    chk("to_bus_err", 64'(bus_err), 64'(1));
    chk("to_halted", 64'(halted), 64'(1));
    chk("to_retired", 64'(retired), 64'(0));

    // timeout inside MEMRD after one retired instruction
    do_reset();
    add_instr(OP_ADDI, 6'b000000, 0, 0);
    add_instr(OP_LW, 6'b000000, 0, int'(MEM_TIMEOUT) + 3);
    add_halt(10);
    run_trace(tr.size());
    chk("to_rd_bus_err", 64'(bus_err), 64'(1));
    chk("to_rd_retired", 64'(retired), 64'(1));

    // unknown opcode
    do_reset();
    add_instr(OP_BAD, 6'b000000, 0, 0);
    add_instr(OP_ADDI, 6'b000000, 0, 0);
    add_halt(5);
    run_trace(tr.size());
`ifdef MC_ILLEGAL_TRAP_EN
    chk("bad_state", 64'(state), 64'(S_HALT));
    chk("bad_illegal", 64'(illegal_op), 64'(1));
    chk("bad_retired", 64'(retired), 64'(0));
`else
    chk("bad_state", 64'(state), 64'(S_FETCH));
    chk("bad_retired", 64'(retired), 64'(2));
`endif

    // asynchronous reset in the middle of a MEMWR wait
    rdy_rand = 1'b0;
    do_reset();
    add_instr(OP_SW, 6'b000000, 0, 40);
    run_trace(7);
    #3;
    chk("mid_wr_state", 64'(state), 64'(S_MEMWR));
    chk("mid_wr_write", 64'(mem_write), 64'(1));
    rst = 1'b1;
    #1;
    chk("arst_mem_write", 64'(mem_write), 64'(0));
    chk("arst_mem_req", 64'(mem_req), 64'(0));
    chk("arst_state", 64'(state), 64'(S_IDLE));
    @(posedge clk); #1;
    do_reset();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
